timer_bank: RTL
===============

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 The block SHALL declare parameter DW, default 16, meaning counter and limit width in bits (DW >= 2).
REQ-002 The block SHALL declare parameter NCH, default 4, meaning number of independent counter channels (1..16).
REQ-003 The block SHALL declare parameter CW, default 2, meaning channel-select width, with ceil(log2(NCH)) <= CW, minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port load_limit, input, 1 bit, meaning one-cycle load request for the channel on load_ch.
REQ-007 The block SHALL have port load_ch, input, CW bits, meaning target channel of a load.
REQ-008 The block SHALL have port cntr_limit, input, DW bits, meaning terminal value loaded into the target channel.
REQ-009 The block SHALL have port oneshot, input, 1 bit, meaning mode loaded with the limit: 0 periodic, 1 one-shot.
REQ-010 The block SHALL have port enable, input, NCH bits, meaning per-channel count enable.
REQ-011 The block SHALL have port cntr, output, NCH*DW bits, meaning channel i count at bits [i*DW +: DW].
REQ-012 The block SHALL have port strb, output, NCH bits, meaning one-cycle terminal-count strobe per channel.
REQ-013 The block SHALL have port armed, output, NCH bits, meaning the channel holds a valid limit and may count.
REQ-014 The block SHALL have port done, output, NCH bits, meaning sticky flag that a one-shot channel has expired.

Function
REQ-015 On a load with cntr_limit > 0, the block SHALL store limit and mode for channel load_ch, set armed, clear done, and zero its cntr and strb on the same edge.
REQ-016 On a load with cntr_limit == 0, the block SHALL clear armed and done and zero cntr and strb, while the stored limit is kept.
REQ-017 The block SHALL ignore a load whose load_ch >= NCH, with no state change in any channel.
REQ-018 On an edge with armed, enable[i] = 1 and cntr != limit, the block SHALL increment cntr by 1 and drive strb low.
REQ-019 On an edge with armed, enable[i] = 1 and cntr == limit, the block SHALL set cntr to 0 and strb high for exactly one cycle; the period is limit+1 enabled cycles.
REQ-020 When enable[i] = 0 or the channel is unarmed, the block SHALL hold cntr and drive strb low.
REQ-021 In one-shot mode, the terminal-count edge SHALL also clear armed and set done; the channel then stays idle until the next load.
REQ-022 In periodic mode, the channel SHALL remain armed indefinitely.
REQ-023 A load to channel k in the same cycle as its terminal count SHALL take priority: no strobe is produced and done is not set.
REQ-024 A load to channel k SHALL NOT affect any other channel, including one strobing in the same cycle.
REQ-025 The block SHALL use no carry out of DW bits; a limit of 2^DW-1 SHALL count to all-ones and wrap to 0 with strobe.
REQ-026 Each output SHALL be a direct register output with no combinational path from input to output.

Reset
REQ-027 While reset is high, the block SHALL force cntr = 0, strb = 0, armed = 0 and done = 0 for all channels, clear all stored limits to 0 and all modes to periodic, and take precedence over load_limit.
REQ-028 The block SHALL decide reset only at the rising clock edge; an asynchronous assertion has no effect until the next edge.
REQ-029 The block SHALL give every register the same value at power-up as after reset.

Structure
REQ-030 The design SHALL place the mode encodings (MODE_PERIODIC = 0, MODE_ONESHOT = 1) in a shared package/include, timer_pkg, for the block and the bench.
REQ-031 The design SHALL implement the per-channel logic as one sub-module, timer_chan (limit, mode, armed, done, cntr, strb), instantiated NCH times by generate.
REQ-032 The top level SHALL contain only channel-select decode, load fan-out and output concatenation.

Verification
REQ-033 The bench SHALL cover: load ch0 limit 3 periodic, enable[0] held high -> cntr0 0,1,2,3,0..., strb[0] high every 4th cycle, armed[0] = 1 throughout.
REQ-034 The bench SHALL cover: load ch1 limit 2 one-shot, enable high -> single strb[1] after 3 enabled cycles, then armed[1] = 0, done[1] = 1, cntr1 frozen at 0.
REQ-035 The bench SHALL cover: ch2 limit 5, toggle enable[2] every cycle -> strobe after 6 enabled cycles (11 clocks), count held during gaps.
REQ-036 The bench SHALL cover: load ch0 in its terminal-count cycle, with ch3 strobing in the same cycle -> strb[0] = 0 and cntr0 = 0; strb[3] = 1 unaffected.
REQ-037 The bench SHALL cover: load limit 0 to an armed channel -> armed = 0; load_ch = NCH (when NCH < 2^CW) -> no channel changes.
REQ-038 The bench SHALL cover: assert reset mid-count with DW = 8, limit 255 -> all outputs 0 next edge, and no strobe until reloaded.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel mode encodings used by the
// design and its testbench.
package timer_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_bank_if.sv
// Load/enable/status bus of the timer bank. The master side issues limit
// loads and per-channel enables; the slave side returns counts and flags.
interface timer_bank_if #(
  parameter int DW  = 16,
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic               load_limit;
  logic [CW-1:0]      load_ch;
  logic [DW-1:0]      cntr_limit;
  logic               oneshot;
  logic [NCH-1:0]     enable;
  logic [NCH*DW-1:0]  cntr;
  logic [NCH-1:0]     strb;
  logic [NCH-1:0]     armed;
  logic [NCH-1:0]     done;

  modport master (
    output load_limit, load_ch, cntr_limit, oneshot, enable,
    input  cntr, strb, armed, done
  );

  modport slave (
    input  load_limit, load_ch, cntr_limit, oneshot, enable,
    output cntr, strb, armed, done
  );
endinterface

// File: rtl/timer_chan.sv
// One timer channel: holds a limit and a mode, counts enabled cycles from 0
// to limit, strobes on the wrap, and in one-shot mode disarms itself and
// raises a sticky done flag. A load always wins over a terminal count.
module timer_chan
  import timer_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] limit_in,
  input  mode_e         mode_in,
  input  logic          en,
  output logic [DW-1:0] cntr,
  output logic          strb,
  output logic          armed,
  output logic          done
);

  logic [DW-1:0] limit_q = '0;
  mode_e         mode_q  = MODE_PERIODIC;
  logic [DW-1:0] cntr_q  = '0;
  logic          strb_q  = 1'b0;
  logic          armed_q = 1'b0;
  logic          done_q  = 1'b0;

  // Channel state update: reset, then load, then counting when armed and enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= '0;
      mode_q  <= MODE_PERIODIC;
      cntr_q  <= '0;
      strb_q  <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      cntr_q <= '0;
      strb_q <= 1'b0;
      done_q <= 1'b0;
      if (limit_in != '0) begin
        limit_q <= limit_in;
        mode_q  <= mode_in;
        armed_q <= 1'b1;
      end else begin
        armed_q <= 1'b0;
      end
    end else if (armed_q && en) begin
      if (cntr_q == limit_q) begin
        cntr_q <= '0;
        strb_q <= 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          armed_q <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        cntr_q <= cntr_q + DW'(1);
        strb_q <= 1'b0;
      end
    end else begin
      strb_q <= 1'b0;
    end
  end

  assign cntr  = cntr_q;
  assign strb  = strb_q;
  assign armed = armed_q;
  assign done  = done_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent timer channels. This level only decodes the
// channel select of a load, fans the load out, and concatenates the
// per-channel registered outputs onto the bus. Selects >= NCH match no
// channel and are therefore ignored.
module timer_bank
  import timer_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  timer_bank_if.slave   bus
);

  logic [NCH*DW-1:0] cntr_w;
  logic [NCH-1:0]    strb_w;
  logic [NCH-1:0]    armed_w;
  logic [NCH-1:0]    done_w;
  mode_e             mode_sel;

  assign mode_sel = bus.oneshot ? MODE_ONESHOT : MODE_PERIODIC;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic hit;
    assign hit = bus.load_limit && (bus.load_ch == CW'(i));

    timer_chan #(.DW(DW)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .load     (hit),
      .limit_in (bus.cntr_limit),
      .mode_in  (mode_sel),
      .en       (bus.enable[i]),
      .cntr     (cntr_w[i*DW +: DW]),
      .strb     (strb_w[i]),
      .armed    (armed_w[i]),
      .done     (done_w[i])
    );
  end

  assign bus.cntr  = cntr_w;
  assign bus.strb  = strb_w;
  assign bus.armed = armed_w;
  assign bus.done  = done_w;

endmodule
